// File: rtl/thumb_inst_aligner.sv
// Thumb halfword aligner: splits 32-bit fetch words into a 4-entry halfword queue,
// detects 16/32-bit encodings and issues one instruction per handshake with its PC.
module thumb_inst_aligner #(
  parameter int unsigned QDEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_valid,
  output logic        fetch_ready,
  input  logic [31:0] fetch_data,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_inst,
  output logic        dec_is32,
  output logic [31:0] dec_pc
);

  localparam int unsigned HW_W  = 16;
  localparam int unsigned PTR_W = 2;
  localparam int unsigned CNT_W = 3;

  logic [HW_W-1:0]  queue [QDEPTH];
  logic [PTR_W-1:0] head;
  logic [CNT_W-1:0] hw_cnt;
  logic             skip;
  logic [31:0]      pc;

  logic [HW_W-1:0]  head_hw;
  logic [HW_W-1:0]  second_hw;
  logic             head_is32;
  logic             push_en;
  logic             pop_en;
  logic [CNT_W-1:0] push_n;
  logic [CNT_W-1:0] pop_n;
  logic [PTR_W-1:0] tail;

  // Decode view of the queue head and the handshake qualifiers
  always_comb begin
    head_hw     = queue[head];
    second_hw   = queue[head + PTR_W'(1)];
    head_is32   = (head_hw[15:13] == 3'b111) && (head_hw[12:11] != 2'b00);
    fetch_ready = (hw_cnt <= CNT_W'(2)) && !flush;
    dec_valid   = !flush && (((hw_cnt >= CNT_W'(1)) && !head_is32) ||
                             (hw_cnt >= CNT_W'(2)));
    push_en     = fetch_valid && fetch_ready;
    pop_en      = dec_valid && dec_ready;
    push_n      = '0;
    if (push_en) begin
      push_n = skip ? CNT_W'(1) : CNT_W'(2);
    end
    pop_n       = '0;
    if (pop_en) begin
      pop_n = head_is32 ? CNT_W'(2) : CNT_W'(1);
    end
    tail        = head + hw_cnt[PTR_W-1:0];
  end

  // Instruction output in the decoder's format; zero unless issuing
  always_comb begin
    dec_inst = '0;
    dec_is32 = 1'b0;
    if (dec_valid) begin
      dec_is32 = head_is32;
      dec_inst = head_is32 ? {head_hw, second_hw} : {head_hw, 16'h0000};
    end
    dec_pc = pc;
  end

  // Queue, pointer, count and PC state; flush overrides any handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(QDEPTH); i++) begin
        queue[i] <= '0;
      end
      head   <= '0;
      hw_cnt <= '0;
      skip   <= 1'b0;
      pc     <= '0;
    end else if (flush) begin
      head   <= '0;
      hw_cnt <= '0;
      skip   <= flush_pc[1];
      pc     <= {flush_pc[31:1], 1'b0};
    end else begin
      // Free slots start at tail; pop reads pre-push contents so they never overlap
      if (push_en) begin
        if (skip) begin
          queue[tail] <= fetch_data[31:16];
          skip        <= 1'b0;
        end else begin
          queue[tail]               <= fetch_data[15:0];
          queue[tail + PTR_W'(1)]   <= fetch_data[31:16];
        end
      end
      head   <= head + pop_n[PTR_W-1:0];
      hw_cnt <= hw_cnt + push_n - pop_n;
      if (pop_en) begin
        pc <= pc + (head_is32 ? 32'd4 : 32'd2);
      end
    end
  end

endmodule

// File: tb/tb_thumb_inst_aligner.sv
// Directed bench for thumb_inst_aligner: linear stimulus with hand-computed expectations.
module tb_thumb_inst_aligner;

  logic        clk;
  logic        rst_n;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_data;
  logic        flush;
  logic [31:0] flush_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_inst;
  logic        dec_is32;
  logic [31:0] dec_pc;

  int n_assert = 0;
  int n_fail   = 0;

  thumb_inst_aligner #(.QDEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fetch_valid(fetch_valid),
    .fetch_ready(fetch_ready),
    .fetch_data (fetch_data),
    .flush      (flush),
    .flush_pc   (flush_pc),
    .dec_valid  (dec_valid),
    .dec_ready  (dec_ready),
    .dec_inst   (dec_inst),
    .dec_is32   (dec_is32),
    .dec_pc     (dec_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue check: valid, instruction, width and PC together
  task automatic chk_issue(input string tag, input logic [31:0] inst, input logic is32,
                           input logic [31:0] pc);
    chk({tag, " valid"}, 32'(dec_valid), 32'd1);
    chk({tag, " inst"},  dec_inst, inst);
    chk({tag, " is32"},  32'(dec_is32), 32'(is32));
    chk({tag, " pc"},    dec_pc, pc);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " valid"}, 32'(dec_valid), 32'd0);
    chk({tag, " inst"},  dec_inst, 32'd0);
    chk({tag, " is32"},  32'(dec_is32), 32'd0);
  endtask

  // Advance one cycle; inputs are driven at the falling edge
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; fetch_valid = 1'b0; fetch_data = '0;
    flush = 1'b0; flush_pc = '0; dec_ready = 1'b0;
    tick(); tick();
    #1;
    chk_idle("in_reset");
    chk("in_reset pc", dec_pc, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("post_reset fetch_ready", 32'(fetch_ready), 32'd1);

    // Two 16-bit ADC T1 halfwords in one word
    tick();
    dec_ready = 1'b1; fetch_valid = 1'b1; fetch_data = 32'h4148_4148;
    #1 chk_idle("adc no bypass");
    tick();
    fetch_valid = 1'b0;
    #1 chk_issue("adc0", 32'h4148_0000, 1'b0, 32'h0);
    tick();
    #1 chk_issue("adc1", 32'h4148_0000, 1'b0, 32'h2);
    tick();
    #1 chk_idle("adc drained");

    // Flush to 0x100, aligned 32-bit ADD imm T3
    flush = 1'b1; flush_pc = 32'h0000_0100; fetch_valid = 1'b1; fetch_data = 32'hDEAD_BEEF;
    #1 chk("flush1 fetch_ready", 32'(fetch_ready), 32'd0);
    tick();
    flush = 1'b0; fetch_data = 32'h0C01_F100;
    #1 chk("flush1 pc", dec_pc, 32'h100);
    tick();
    fetch_valid = 1'b0;
    #1 chk_issue("add32", 32'hF100_0C01, 1'b1, 32'h100);
    tick();
    #1 chk_idle("add32 drained");

    // Flush to 0x102: straddling 32-bit instruction, lower halfword dropped
    flush = 1'b1; flush_pc = 32'h0000_0102;
    tick();
    flush = 1'b0; fetch_valid = 1'b1; fetch_data = 32'hF100_ABCD;
    tick();
    fetch_data = 32'h1C08_0C01;
    #1 chk_idle("wait2");
    chk("wait2 fetch_ready", 32'(fetch_ready), 32'd1);
    tick();
    fetch_valid = 1'b0;
    #1 chk_issue("straddle", 32'hF100_0C01, 1'b1, 32'h102);
    chk("straddle full", 32'(fetch_ready), 32'd0);
    tick();
    #1 chk_issue("after straddle", 32'h1C08_0000, 1'b0, 32'h106);
    chk("after straddle ready", 32'(fetch_ready), 32'd1);
    tick();

    // Backpressure: decoder stalled while 16-bit words arrive
    dec_ready = 1'b0; fetch_valid = 1'b1; fetch_data = 32'h2211_2200;
    tick();
    fetch_data = 32'h2433_2422;
    #1 chk_issue("stall a", 32'h2200_0000, 1'b0, 32'h108);
    chk("stall a ready", 32'(fetch_ready), 32'd1);
    tick();
    fetch_data = 32'h2655_2644;
    #1 chk("stall full ready", 32'(fetch_ready), 32'd0);
    chk_issue("stall held", 32'h2200_0000, 1'b0, 32'h108);
    tick();
    #1 chk_issue("stall held2", 32'h2200_0000, 1'b0, 32'h108);
    fetch_valid = 1'b0; dec_ready = 1'b1;
    #1 chk_issue("drain0", 32'h2200_0000, 1'b0, 32'h108);
    tick();
    #1 chk_issue("drain1", 32'h2211_0000, 1'b0, 32'h10A);
    tick();
    #1 chk_issue("drain2", 32'h2422_0000, 1'b0, 32'h10C);
    tick();
    #1 chk_issue("drain3", 32'h2433_0000, 1'b0, 32'h10E);
    tick();
    #1 chk_idle("drained");

    // Flush while both handshakes are offered
    dec_ready = 1'b0; fetch_valid = 1'b1; fetch_data = 32'h3001_3000;
    tick();
    dec_ready = 1'b1; flush = 1'b1; flush_pc = 32'h0000_0200; fetch_data = 32'h5555_5555;
    #1 chk_idle("flush2 cycle");
    chk("flush2 fetch_ready", 32'(fetch_ready), 32'd0);
    tick();
    flush = 1'b0; fetch_valid = 1'b0;
    #1 chk_idle("flush2 empty");
    chk("flush2 pc", dec_pc, 32'h200);
    fetch_valid = 1'b1; fetch_data = 32'h3003_3002; dec_ready = 1'b0;
    tick();
    fetch_valid = 1'b0;
    #1 chk_issue("flush2 first", 32'h3002_0000, 1'b0, 32'h200);

    // Build hw_cnt = 3, then reset asynchronously mid-cycle
    flush = 1'b1; flush_pc = 32'h0000_0302;
    tick();
    flush = 1'b0; fetch_valid = 1'b1; fetch_data = 32'h3005_3004;
    tick();
    fetch_data = 32'h3007_3006;
    tick();
    fetch_valid = 1'b0;
    #1 chk_issue("cnt3", 32'h3005_0000, 1'b0, 32'h302);
    chk("cnt3 fetch_ready", 32'(fetch_ready), 32'd0);
    #1 rst_n = 1'b0;
    #1 chk_idle("async reset");
    chk("async reset pc", dec_pc, 32'd0);
    chk("async reset ready", 32'(fetch_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1; fetch_valid = 1'b1; fetch_data = 32'h3009_3008; dec_ready = 1'b1;
    #1 chk_idle("post reset2");
    tick();
    fetch_valid = 1'b0;
    #1 chk_issue("post reset2 first", 32'h3008_0000, 1'b0, 32'h0);
    tick();
    #1 chk_issue("post reset2 second", 32'h3009_0000, 1'b0, 32'h2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
